vlc_packer: RTL and testbench
=============================

VLC_PACKER -- requirements
Module: vlc_packer

Interface
REQ-001 SHALL have parameter CODE_W, default 16, maximum code length in bits (1..WORD_W).
REQ-002 SHALL have parameter WORD_W, default 32, packed output word width.
REQ-003 SHALL have parameter DEPTH, default 8, output FIFO entries, power of 2, >=2.
REQ-004 SHALL have parameter THRESH, default 6, FIFO level at or above which threshold asserts.
REQ-005 SHALL have port clock  in  1  rising-edge clock.
REQ-006 SHALL have port resetn  in  1  synchronous, active-low reset.
REQ-007 SHALL have port ce  in  1  clock enable; low freezes all state.
REQ-008 SHALL have port in_valid  in  1  code beat valid.
REQ-009 SHALL have port in_ready  out  1  beat/flush accepted this cycle when high.
REQ-010 SHALL have port in_code  in  CODE_W  code, bit 0 emitted first.
REQ-011 SHALL have port in_len  in  clog2(CODE_W+1)  code length, 0..CODE_W.
REQ-012 SHALL have port flush  in  1  end-of-stream request, qualified by in_ready.
REQ-013 SHALL have port out_valid  out  1  FIFO head valid.
REQ-014 SHALL have port out_ready  in  1  consumer pops head when out_valid & out_ready.
REQ-015 SHALL have port out_word  out  WORD_W  packed data at FIFO head.
REQ-016 SHALL have port out_bits  out  clog2(WORD_W+1)  valid bits in out_word (WORD_W for full words).
REQ-017 SHALL have port out_last  out  1  head is the final word of a flushed stream.
REQ-018 SHALL have port level  out  clog2(DEPTH+1)  FIFO occupancy.
REQ-019 SHALL have ports threshold, len_err  out  1 each  level>=THRESH; sticky illegal-length flag.

Function
REQ-020 SHALL accept a beat when ce & in_valid & in_ready; flush accepted when ce & flush & in_ready.
REQ-021 SHALL pack LSB-first: masked code (bits >= in_len zeroed) OR-ed into accumulator at bit position acc_bits; acc_bits += in_len.
REQ-022 SHALL hold accumulator of WORD_W+CODE_W bits; acc_bits never exceeds WORD_W+CODE_W-1 between cycles.
REQ-023 SHALL, when post-accept acc_bits >= WORD_W, push low WORD_W bits (out_bits=WORD_W, out_last=0) same edge, shift accumulator right by WORD_W, acc_bits -= WORD_W.
REQ-024 SHALL present a pushed word on out_valid in the cycle after the accepting edge (1-cycle latency).
REQ-025 SHALL drive in_ready = ce & (level < DEPTH) & (state == RUN); no push ever occurs with FIFO full.
REQ-026 SHALL run FSM states RUN, TAIL: on accepted flush, if no full-word push this edge, push remainder (out_bits=acc_bits, out_last=1), clear accumulator, stay RUN.
REQ-027 SHALL, on flush with a same-cycle full-word push, push the full word, enter TAIL; TAIL waits for level<DEPTH, pushes remainder with out_last=1, returns to RUN.
REQ-028 SHALL, on flush with acc_bits==0 after accept, push out_word=0, out_bits=0, out_last=1.
REQ-029 SHALL support simultaneous push and pop; level unchanged.
REQ-030 SHALL treat in_len > CODE_W as CODE_W and set len_err until reset.
REQ-031 SHALL, with ce low, hold all state, force in_ready=0, ignore out_ready (no pop); out_valid reflects held state.
REQ-032 SHALL produce zero-valued unused upper bits in partial words.

Reset
REQ-033 SHALL on resetn low at a ce-independent clock edge clear accumulator, acc_bits, FIFO pointers, len_err, state=RUN.
REQ-034 SHALL give reset values: out_valid=0, level=0, threshold=0, len_err=0, out_word=0, out_bits=0, out_last=0, in_ready=ce.
REQ-035 SHALL discard in-flight data on reset mid-stream; no partial word emitted.

Verification (WORD_W=32, CODE_W=16, DEPTH=8)
REQ-036 SHALL test: reset with FIFO holding 3 words -> next cycle level=0, out_valid=0, in_ready=1.
REQ-037 SHALL test: beats (0xAAAA,16),(0x5555,16) -> next cycle out_word=0x5555AAAA, out_bits=32, out_last=0.
REQ-038 SHALL test: (0xFFF,12),(0x000,12),(0xABC,12), then flush -> words 0xBC000FFF/32/0 then 0x0000000A/4/1.
REQ-039 SHALL test: acc holds 0xFFFFF/20 bits, beat (0x1234,16)+flush same cycle -> 0x234FFFFF/32/0, in_ready low one cycle (TAIL), then 0x00000001/4/1.
REQ-040 SHALL test: out_ready=0, 8 full words pushed -> level=8, threshold=1, in_ready=0; one pop -> in_ready=1 next cycle.
REQ-041 SHALL test: flush on empty accumulator -> 0x00000000/0/1; beat (0x3,20) -> len_err=1, code packed as 16 bits.

Source files
------------

// File: rtl/vlc_packer.sv
// Variable-length code packer: LSB-first bit accumulator feeding a small output
// FIFO, with flush/tail handling so every stream ends in a marked partial word.
module vlc_packer #(
    parameter int CODE_W = 16,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 8,
    parameter int THRESH = 6
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CODE_W-1:0]            in_code,
    input  logic [$clog2(CODE_W+1)-1:0]  in_len,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_W-1:0]            out_word,
    output logic [$clog2(WORD_W+1)-1:0]  out_bits,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         threshold,
    output logic                         len_err
);

    localparam int ACC_W  = WORD_W + CODE_W;
    localparam int CNT_W  = $clog2(ACC_W + 1);
    localparam int LEN_W  = $clog2(CODE_W + 1);
    localparam int BITS_W = $clog2(WORD_W + 1);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(CODE_W);
    localparam logic [CNT_W-1:0]  CNT_WORD  = CNT_W'(WORD_W);
    localparam logic [BITS_W-1:0] BITS_FULL = BITS_W'(WORD_W);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_THR   = LVL_W'(THRESH);

    typedef enum logic {S_RUN, S_TAIL} state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_acc_bits;
    logic [WORD_W-1:0]   r_mem_word [DEPTH];
    logic [BITS_W-1:0]   r_mem_bits [DEPTH];
    logic                r_mem_last [DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [LVL_W-1:0]    r_level;
    logic                r_len_err;

    logic                w_ready;
    logic                w_beat;
    logic                w_flush;
    logic                w_tail;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [LEN_W-1:0]    w_len_sat;
    logic [LEN_W-1:0]    w_len;
    logic [CODE_W-1:0]   w_code;
    logic [ACC_W-1:0]    w_acc;
    logic [CNT_W-1:0]    w_bits;
    logic [BITS_W-1:0]   w_push_bits;

    assign w_ready   = ce & (r_level < LVL_FULL) & (r_state == S_RUN);
    assign w_beat    = w_ready & in_valid;
    assign w_flush   = w_ready & flush;
    assign w_len_sat = (in_len > LEN_MAX) ? LEN_MAX : in_len;
    assign w_len     = w_beat ? w_len_sat : '0;
    assign w_code    = in_code & ~({CODE_W{1'b1}} << w_len);
    assign w_acc     = r_acc | (ACC_W'(w_code) << r_acc_bits);
    assign w_bits    = r_acc_bits + CNT_W'(w_len);
    assign w_full    = (w_bits >= CNT_WORD);
    assign w_tail    = ce & (r_state == S_TAIL) & (r_level < LVL_FULL);
    assign w_pop     = ce & out_ready & (r_level != '0);

    // In TAIL no beat is accepted, so w_acc/w_bits equal the held remainder and
    // the flush and tail pushes share one data path.
    assign w_push      = w_full | w_flush | w_tail;
    assign w_push_bits = w_full ? BITS_FULL : BITS_W'(w_bits);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= S_RUN;
            r_acc      <= '0;
            r_acc_bits <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_len_err  <= 1'b0;
        end else if (ce) begin
            if (w_full) begin
                r_acc      <= w_acc >> WORD_W;
                r_acc_bits <= w_bits - CNT_WORD;
                if (w_flush)
                    r_state <= S_TAIL;
            end else if (w_flush || w_tail) begin
                r_acc      <= '0;
                r_acc_bits <= '0;
                r_state    <= S_RUN;
            end else begin
                r_acc      <= w_acc;
                r_acc_bits <= w_bits;
            end

            if (w_beat && (in_len > LEN_MAX))
                r_len_err <= 1'b1;

            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);

            if (w_push && !w_pop)
                r_level <= r_level + LVL_W'(1);
            else if (!w_push && w_pop)
                r_level <= r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (resetn && w_push) begin
            r_mem_word[r_wptr] <= w_acc[WORD_W-1:0];
            r_mem_bits[r_wptr] <= w_push_bits;
            r_mem_last[r_wptr] <= ~w_full;
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = (r_level != '0);
    assign out_word  = out_valid ? r_mem_word[r_rptr] : '0;
    assign out_bits  = out_valid ? r_mem_bits[r_rptr] : '0;
    assign out_last  = out_valid ? r_mem_last[r_rptr] : 1'b0;
    assign level     = r_level;
    assign threshold = (r_level >= LVL_THR);
    assign len_err   = r_len_err;

endmodule

// File: tb/tb_vlc_packer.sv
// Bench for vlc_packer: directed vector table, flush/tail/full corner sequences,
// and random traffic checked against a bit-queue reference model.
module tb_vlc_packer;

    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic        clock = 1'b0;
    logic        resetn;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_code;
    logic [4:0]  in_len;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_bits;
    logic        out_last;
    logic [3:0]  level;
    logic        threshold;
    logic        len_err;

    vlc_packer #(.CODE_W(16), .WORD_W(32), .DEPTH(8), .THRESH(6)) dut (
        .clock(clock), .resetn(resetn), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_len(in_len),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_bits(out_bits), .out_last(out_last),
        .level(level), .threshold(threshold), .len_err(len_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] w;
        int          b;
        bit          l;
    } word_t;

    // Reference: pending stream bits in order, plus the words the packer owes.
    bit    bq[$];
    word_t wq[$];
    bit    m_len_err;

    typedef struct {
        bit          v;
        logic [15:0] c;
        logic [4:0]  l;
        bit          f;
        bit          r;
        bit          e_valid;
        logic [31:0] e_word;
        logic [5:0]  e_bits;
        bit          e_last;
        logic [3:0]  e_level;
        bit          e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit v, logic [15:0] c, logic [4:0] l, bit f, bit r,
                                bit ev, logic [31:0] ew, logic [5:0] eb, bit el,
                                logic [3:0] elv, bit ee);
        vec_t t;
        t.v = v; t.c = c; t.l = l; t.f = f; t.r = r;
        t.e_valid = ev; t.e_word = ew; t.e_bits = eb; t.e_last = el;
        t.e_level = elv; t.e_err = ee;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic emit(input int n, input bit last);
        word_t e;
        e.w = '0;
        for (int i = 0; i < n; i++)
            e.w[i] = bq.pop_front();
        e.b = n;
        e.l = last;
        wq.push_back(e);
    endtask

    task automatic model_beat(input logic [15:0] c, input logic [4:0] len);
        int n;
        n = int'(len);
        if (n > 16) begin
            m_len_err = 1'b1;
            n = 16;
        end
        for (int i = 0; i < n; i++)
            bq.push_back(c[i]);
        while (bq.size() >= 32)
            emit(32, 1'b0);
    endtask

    task automatic do_reset(input bit ce_val);
        resetn = 1'b0; ce = ce_val; in_valid = 1'b1; in_code = 16'hFFFF;
        in_len = 5'd16; flush = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        resetn = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        bq.delete(); wq.delete(); m_len_err = 1'b0;
        #1;
    endtask

    // One clock: drive inputs, observe handshakes, check pops, advance model.
    task automatic cycle(input bit v, input logic [15:0] c, input logic [4:0] l,
                         input bit f, input bit r, input bit e);
        bit acc, fla, pop;
        word_t x;
        in_valid = v; in_code = c; in_len = l; flush = f; out_ready = r; ce = e;
        #1;
        acc = in_ready && v;
        fla = in_ready && f;
        pop = e && r && out_valid;
        if (pop) begin
            if (wq.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL pop_unexpected: got word 0x%0h expected no word", out_word);
            end else begin
                x = wq.pop_front();
                chk("pop_word", 64'(out_word), 64'(x.w));
                chk("pop_bits", 64'(out_bits), 64'(x.b));
                chk("pop_last", 64'(out_last), 64'(x.l));
            end
        end
        if (acc) model_beat(c, l);
        if (fla) emit(bq.size(), 1'b1);
        @(posedge clock); #1;
    endtask

    initial begin
        resetn = 1'b0; ce = 1'b1; in_valid = 1'b0; in_code = '0; in_len = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reset values
        do_reset(1'b1);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_thr", 64'(threshold), 64'(0));
        chk("rst_err", 64'(len_err), 64'(0));
        chk("rst_word", 64'(out_word), 64'(0));
        chk("rst_bits", 64'(out_bits), 64'(0));
        chk("rst_last", 64'(out_last), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));

        // Directed vector table
        tbl.push_back(mk(Y, 16'hAAAA, 5'd16, N, N, N, 32'h0,        6'd0,  N, 4'd0, N));
        tbl.push_back(mk(Y, 16'h5555, 5'd16, N, N, Y, 32'h5555AAAA, 6'd32, N, 4'd1, N));
        tbl.push_back(mk(N, 16'h0,    5'd0,  N, Y, N, 32'h0,        6'd0,  N, 4'd0, N));
        tbl.push_back(mk(Y, 16'h0FFF, 5'd12, N, N, N, 32'h0,        6'd0,  N, 4'd0, N));
        tbl.push_back(mk(Y, 16'h0000, 5'd12, N, N, N, 32'h0,        6'd0,  N, 4'd0, N));
        tbl.push_back(mk(Y, 16'h0ABC, 5'd12, N, N, Y, 32'hBC000FFF, 6'd32, N, 4'd1, N));
        tbl.push_back(mk(N, 16'h0,    5'd0,  Y, N, Y, 32'hBC000FFF, 6'd32, N, 4'd2, N));
        tbl.push_back(mk(N, 16'h0,    5'd0,  N, Y, Y, 32'h0000000A, 6'd4,  Y, 4'd1, N));
        tbl.push_back(mk(N, 16'h0,    5'd0,  N, Y, N, 32'h0,        6'd0,  N, 4'd0, N));
        tbl.push_back(mk(N, 16'h0,    5'd0,  Y, N, Y, 32'h0,        6'd0,  Y, 4'd1, N));
        tbl.push_back(mk(N, 16'h0,    5'd0,  N, Y, N, 32'h0,        6'd0,  N, 4'd0, N));
        tbl.push_back(mk(Y, 16'hFFFF, 5'd4,  Y, N, Y, 32'h0000000F, 6'd4,  Y, 4'd1, N));
        tbl.push_back(mk(N, 16'h0,    5'd0,  N, Y, N, 32'h0,        6'd0,  N, 4'd0, N));
        tbl.push_back(mk(Y, 16'h0003, 5'd20, N, N, N, 32'h0,        6'd0,  N, 4'd0, Y));
        tbl.push_back(mk(N, 16'h0,    5'd0,  Y, N, Y, 32'h00000003, 6'd16, Y, 4'd1, Y));
        tbl.push_back(mk(N, 16'h0,    5'd0,  N, Y, N, 32'h0,        6'd0,  N, 4'd0, Y));
        do_reset(1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, tbl[i].c, tbl[i].l, tbl[i].f, tbl[i].r, 1'b1);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
            chk($sformatf("vec%0d_word", i),  64'(out_word),  64'(tbl[i].e_word));
            chk($sformatf("vec%0d_bits", i),  64'(out_bits),  64'(tbl[i].e_bits));
            chk($sformatf("vec%0d_last", i),  64'(out_last),  64'(tbl[i].e_last));
            chk($sformatf("vec%0d_level", i), 64'(level),     64'(tbl[i].e_level));
            chk($sformatf("vec%0d_err", i),   64'(len_err),   64'(tbl[i].e_err));
            chk($sformatf("vec%0d_ready", i), 64'(in_ready),  64'(1));
        end

        // Reset with 3 words queued and 16 bits pending; ce low during reset
        do_reset(1'b1);
        for (int k = 0; k < 7; k++)
            cycle(Y, 16'hAAAA, 5'd16, N, N, 1'b1);
        chk("pre_rst_level", 64'(level), 64'(3));
        do_reset(1'b0);
        chk("mid_rst_level", 64'(level), 64'(0));
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(1));
        cycle(N, 16'h0, 5'd0, Y, N, 1'b1);
        chk("mid_rst_flush_bits", 64'(out_bits), 64'(0));
        chk("mid_rst_flush_word", 64'(out_word), 64'(0));
        chk("mid_rst_flush_last", 64'(out_last), 64'(1));
        cycle(N, 16'h0, 5'd0, N, Y, 1'b1);

        // Flush together with a full-word push goes through TAIL
        do_reset(1'b1);
        cycle(Y, 16'hFFFF, 5'd16, N, N, 1'b1);
        cycle(Y, 16'h000F, 5'd4,  N, N, 1'b1);
        cycle(Y, 16'h1234, 5'd16, Y, N, 1'b1);
        chk("tail_word", 64'(out_word), 64'h234FFFFF);
        chk("tail_bits", 64'(out_bits), 64'(32));
        chk("tail_last", 64'(out_last), 64'(0));
        chk("tail_ready_low", 64'(in_ready), 64'(0));
        cycle(N, 16'h0, 5'd0, N, N, 1'b1);
        chk("tail_ready_back", 64'(in_ready), 64'(1));
        chk("tail_level", 64'(level), 64'(2));
        cycle(N, 16'h0, 5'd0, N, Y, 1'b1);
        chk("tail_rem_word", 64'(out_word), 64'h1);
        chk("tail_rem_bits", 64'(out_bits), 64'(4));
        chk("tail_rem_last", 64'(out_last), 64'(1));
        cycle(N, 16'h0, 5'd0, N, Y, 1'b1);
        chk("tail_drained", 64'(level), 64'(0));

        // Fill the FIFO, threshold boundary, full back-pressure, ce freeze
        do_reset(1'b1);
        for (int k = 0; k < 16; k++) begin
            cycle(Y, 16'($urandom), 5'd16, N, N, 1'b1);
            chk($sformatf("fill%0d_level", k), 64'(level), 64'((k + 1) / 2));
            chk($sformatf("fill%0d_thr", k), 64'(threshold), 64'(((k + 1) / 2) >= 6));
        end
        chk("full_ready", 64'(in_ready), 64'(0));
        cycle(Y, 16'h1111, 5'd16, N, N, 1'b1);
        chk("full_hold_level", 64'(level), 64'(8));
        cycle(Y, 16'h2222, 5'd16, Y, Y, 1'b0);
        chk("ce_low_ready", 64'(in_ready), 64'(0));
        chk("ce_low_level", 64'(level), 64'(8));
        chk("ce_low_valid", 64'(out_valid), 64'(1));
        cycle(N, 16'h0, 5'd0, N, Y, 1'b1);
        chk("pop_level", 64'(level), 64'(7));
        chk("pop_ready", 64'(in_ready), 64'(1));

        // TAIL stalls while full, then completes after a pop frees a slot
        cycle(Y, 16'h00C3, 5'd16, N, N, 1'b1);
        cycle(Y, 16'h3C00, 5'd16, Y, N, 1'b1);
        chk("tfull_level", 64'(level), 64'(8));
        chk("tfull_ready", 64'(in_ready), 64'(0));
        cycle(N, 16'h0, 5'd0, N, N, 1'b1);
        cycle(N, 16'h0, 5'd0, N, N, 1'b1);
        chk("tfull_stall_level", 64'(level), 64'(8));
        cycle(N, 16'h0, 5'd0, N, Y, 1'b1);
        chk("tfull_pop_level", 64'(level), 64'(7));
        chk("tfull_pop_ready", 64'(in_ready), 64'(0));
        cycle(N, 16'h0, 5'd0, N, N, 1'b1);
        chk("tfull_push_level", 64'(level), 64'(8));
        for (int k = 0; k < 10; k++)
            cycle(N, 16'h0, 5'd0, N, Y, 1'b1);
        chk("tfull_drain_level", 64'(level), 64'(0));
        chk("tfull_drain_model", 64'(wq.size()), 64'(0));

        // Random traffic against the reference model
        do_reset(1'b1);
        for (int k = 0; k < 4000; k++) begin
            logic [4:0] l;
            l = ($urandom % 20 == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            cycle(1'($urandom), 16'($urandom), l, ($urandom % 12) == 0,
                  ($urandom % 3) != 0, ($urandom % 8) != 0);
        end
        for (int k = 0; k < 40; k++)
            cycle(N, 16'h0, 5'd0, k == 20, Y, 1'b1);
        chk("rand_level", 64'(level), 64'(0));
        chk("rand_model_empty", 64'(wq.size()), 64'(0));
        chk("rand_len_err", 64'(len_err), 64'(m_len_err));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
